pre_fetch_stage: RTL and testbench

PRE_FETCH_STAGE -- requirements
Module: pre_fetch_stage

---
 rtl/pre_fetch_stage.sv | 170 +++++++++++++++++
 tb/tb_pre_fetch_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pre_fetch_stage.sv
// Pre-fetch stage: owns the fetch PC, issues I-cache requests, applies redirects.
// Ports: clk/reset; fs_allowin, fs_to_pfs_valid from fetch; br_op, bpu_flush/bpu_target
// from decode/BPU; pipeline_flush, c0_epc, refetch_pc from the back end;
// icache_req/icache_addr/icache_addr_ok to the I-cache; pfs_to_fs_bus to fetch.
// Optional macro PFS_ADEL_CHECK_EN: raise AdEL on a misaligned PC instead of masking it.

package pfs_pkg;
  typedef logic [31:0] virt_t;

  typedef struct packed {
    logic ex;
    logic eret;
    logic tlb_op;
    logic cache_op;
  } pipeline_flush_t;

  typedef struct packed {
    logic       ex;
    logic [4:0] exccode;
    virt_t      badvaddr;
    logic       tlb_refill;
  } pfs_exc_t;

  typedef struct packed {
    logic     valid;
    logic     req;
    logic     br_op;
    virt_t    pc;
    pfs_exc_t exception;
  } pfs_to_fs_bus_t;

  typedef enum logic {
    RUN  = 1'b0,
    SLOT = 1'b1
  } pfs_state_e;
endpackage

module pre_fetch_stage
  import pfs_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            fs_allowin,
  input  logic            fs_to_pfs_valid,
  input  logic            br_op,
  input  logic            bpu_flush,
  input  logic [31:0]     bpu_target,
  input  pipeline_flush_t pipeline_flush,
  input  virt_t           c0_epc,
  input  logic [31:0]     refetch_pc,
  output logic            icache_req,
  output logic [31:0]     icache_addr,
  input  logic            icache_addr_ok,
  output pfs_to_fs_bus_t  pfs_to_fs_bus
);

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VEC  = 32'hBFC0_0380;

  pfs_state_e  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pend_pc, pend_nxt;
  logic        pfs_valid;

  logic        live;
  logic        flush_any;
  logic        redir;
  logic        accept;
  logic        xfer;
  pfs_exc_t    exc;

  // Fetch stage occupancy does not gate pre-fetch; fs_allowin covers it.
  logic unused_fs_valid;
  assign unused_fs_valid = fs_to_pfs_valid;

  assign live      = pfs_valid && !reset;
  assign flush_any = pipeline_flush.ex | pipeline_flush.eret |
                     pipeline_flush.tlb_op | pipeline_flush.cache_op;
  // A branch redirect without br_op jumps now; with br_op the current
  // fetch is the delay slot and must still go out.
  assign redir     = flush_any ||
                     (state == RUN && bpu_flush && !br_op);

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      pend_pc   <= '0;
      pfs_valid <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      pend_pc   <= pend_nxt;
      pfs_valid <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pend_nxt  = pend_pc;
    if (pipeline_flush.ex) begin
      pc_nxt    = EXC_VEC;
      pend_nxt  = '0;
      state_nxt = RUN;
    end else if (pipeline_flush.eret) begin
      pc_nxt    = c0_epc;
      pend_nxt  = '0;
      state_nxt = RUN;
    end else if (pipeline_flush.tlb_op || pipeline_flush.cache_op) begin
      pc_nxt    = refetch_pc;
      pend_nxt  = '0;
      state_nxt = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (bpu_flush && !br_op) begin
            pc_nxt = bpu_target;
          end else if (bpu_flush && br_op) begin
            // Delay slot leaving this cycle: go straight to the target.
            if (xfer) begin
              pc_nxt = bpu_target;
            end else begin
              pend_nxt  = bpu_target;
              state_nxt = SLOT;
            end
          end else if (xfer) begin
            pc_nxt = pc + 32'd4;
          end
        end
        SLOT: begin
          if (xfer) begin
            pc_nxt    = pend_pc;
            state_nxt = RUN;
          end
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  always_comb begin
    exc = '0;
`ifdef PFS_ADEL_CHECK_EN
    if (live && pc[1:0] != 2'b00) begin
      exc.ex       = 1'b1;
      exc.exccode  = 5'h04;
      exc.badvaddr = pc;
    end
    icache_addr = pc;
`else
    icache_addr = {pc[31:2], 2'b00};
`endif
    icache_req = live && fs_allowin && !exc.ex && !redir;
    accept     = icache_req && icache_addr_ok;
    xfer       = accept ||
                 (live && fs_allowin && exc.ex && !redir);
    pfs_to_fs_bus.valid     = xfer;
    pfs_to_fs_bus.req       = accept;
    pfs_to_fs_bus.br_op     = br_op;
    pfs_to_fs_bus.pc        = pc;
    pfs_to_fs_bus.exception = exc;
  end

endmodule

// File: tb/tb_pre_fetch_stage.sv
// Directed bench for pre_fetch_stage: reset, sequential fetch, stalls,
// branch/delay-slot handling, pipeline flush priority, wrap and AdEL.

module tb_pre_fetch_stage;
  import pfs_pkg::*;

  logic            clk;
  logic            reset;
  logic            fs_allowin;
  logic            fs_to_pfs_valid;
  logic            br_op;
  logic            bpu_flush;
  logic [31:0]     bpu_target;
  pipeline_flush_t pf;
  virt_t           c0_epc;
  logic [31:0]     refetch_pc;
  logic            icache_req;
  logic [31:0]     icache_addr;
  logic            icache_addr_ok;
  pfs_to_fs_bus_t  bus;

  int n_chk;
  int n_fail;

  pre_fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .fs_allowin      (fs_allowin),
    .fs_to_pfs_valid (fs_to_pfs_valid),
    .br_op           (br_op),
    .bpu_flush       (bpu_flush),
    .bpu_target      (bpu_target),
    .pipeline_flush  (pf),
    .c0_epc          (c0_epc),
    .refetch_pc      (refetch_pc),
    .icache_req      (icache_req),
    .icache_addr     (icache_addr),
    .icache_addr_ok  (icache_addr_ok),
    .pfs_to_fs_bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet;
    br_op      = 1'b0;
    bpu_flush  = 1'b0;
    bpu_target = '0;
    pf         = '0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    fs_to_pfs_valid = 1'b0;
    fs_allowin      = 1'b1;
    icache_addr_ok  = 1'b1;
    c0_epc          = '0;
    refetch_pc      = 32'h0000_9000;
    quiet();
    reset      = 1'b1;
    bpu_flush  = 1'b1;
    bpu_target = 32'h1234_5678;
    pf.ex      = 1'b1;

    @(negedge clk);
    chk("rst_req", icache_req, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_busreq", bus.req, 0);
    chk("rst_exc", bus.exception, 0);
    chk("rst_pc", icache_addr, 32'hBFC0_0000);

    tick();
    tick();
    reset = 1'b0;
    quiet();
    @(negedge clk);
    chk("post_rst_req", icache_req, 0);
    chk("post_rst_pc", icache_addr, 32'hBFC0_0000);

    tick();
    @(negedge clk);
    chk("seq0_addr", icache_addr, 32'hBFC0_0000);
    chk("seq0_req", icache_req, 1);
    chk("seq0_busreq", bus.req, 1);
    chk("seq0_valid", bus.valid, 1);
    tick();
    @(negedge clk);
    chk("seq1_addr", icache_addr, 32'hBFC0_0004);
    chk("seq1_req", icache_req, 1);
    tick();
    @(negedge clk);
    chk("seq2_addr", icache_addr, 32'hBFC0_0008);
    tick();
    @(negedge clk);
    chk("seq3_addr", icache_addr, 32'hBFC0_000C);

    tick();
    icache_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_addr", icache_addr, 32'hBFC0_0010);
      chk("stall_valid", bus.valid, 0);
      tick();
    end
    icache_addr_ok = 1'b1;
    @(negedge clk);
    chk("stall_rel_addr", icache_addr, 32'hBFC0_0010);
    chk("stall_rel_req", bus.req, 1);
    tick();
    br_op      = 1'b1;
    fs_allowin = 1'b0;
    @(negedge clk);
    chk("after_stall_addr", icache_addr, 32'hBFC0_0014);
    chk("brop_pass", bus.br_op, 1);
    chk("noallow_req", icache_req, 0);
    chk("noallow_valid", bus.valid, 0);

    tick();
    fs_allowin = 1'b1;
    br_op      = 1'b0;
    bpu_flush  = 1'b1;
    bpu_target = 32'h8000_0000;
    @(negedge clk);
    chk("noallow_hold", icache_addr, 32'hBFC0_0014);
    chk("bpu_supp_req", icache_req, 0);
    tick();
    quiet();
    @(negedge clk);
    chk("bpu_tgt_addr", icache_addr, 32'h8000_0000);
    chk("bpu_tgt_req", icache_req, 1);
    tick();
    tick();
    br_op          = 1'b1;
    bpu_flush      = 1'b1;
    bpu_target     = 32'h8000_1000;
    icache_addr_ok = 1'b0;
    @(negedge clk);
    chk("slot_pc", icache_addr, 32'h8000_0008);
    chk("slot_req", icache_req, 1);
    chk("slot_wait_valid", bus.valid, 0);
    tick();
    quiet();
    icache_addr_ok = 1'b1;
    @(negedge clk);
    chk("slot_fetch_addr", icache_addr, 32'h8000_0008);
    chk("slot_fetch_valid", bus.valid, 1);
    tick();
    br_op      = 1'b1;
    bpu_flush  = 1'b1;
    bpu_target = 32'h8000_2000;
    @(negedge clk);
    chk("br_tgt_addr", icache_addr, 32'h8000_1000);
    chk("br_same_valid", bus.valid, 1);
    tick();
    quiet();
    @(negedge clk);
    chk("br_same_tgt", icache_addr, 32'h8000_2000);

    br_op          = 1'b1;
    bpu_flush      = 1'b1;
    bpu_target     = 32'h8000_3000;
    icache_addr_ok = 1'b0;
    tick();
    quiet();
    pf.ex          = 1'b1;
    bpu_flush      = 1'b1;
    bpu_target     = 32'h8000_4000;
    icache_addr_ok = 1'b1;
    @(negedge clk);
    chk("ex_supp_req", icache_req, 0);
    chk("ex_supp_valid", bus.valid, 0);
    tick();
    quiet();
    @(negedge clk);
    chk("ex_vec_addr", icache_addr, 32'hBFC0_0380);
    chk("ex_vec_req", icache_req, 1);
    tick();
    @(negedge clk);
    chk("ex_pend_drop", icache_addr, 32'hBFC0_0384);

    pf.eret    = 1'b1;
    pf.tlb_op  = 1'b1;
    c0_epc     = 32'h8000_0102;
    @(negedge clk);
    chk("eret_supp_req", icache_req, 0);
    tick();
    quiet();
    @(negedge clk);
`ifdef PFS_ADEL_CHECK_EN
    chk("adel_valid", bus.valid, 1);
    chk("adel_busreq", bus.req, 0);
    chk("adel_req", icache_req, 0);
    chk("adel_ex", bus.exception.ex, 1);
    chk("adel_code", bus.exception.exccode, 5'h04);
    chk("adel_bad", bus.exception.badvaddr, 32'h8000_0102);
    chk("adel_refill", bus.exception.tlb_refill, 0);
`else
    chk("eret_addr", icache_addr, 32'h8000_0100);
    chk("eret_buspc", bus.pc, 32'h8000_0102);
    chk("eret_exc", bus.exception, 0);
    chk("eret_req", icache_req, 1);
`endif

    pf.tlb_op  = 1'b1;
    refetch_pc = 32'h8000_0200;
    tick();
    quiet();
    @(negedge clk);
    chk("tlb_refetch", icache_addr, 32'h8000_0200);

    pf.cache_op = 1'b1;
    refetch_pc  = 32'h8000_0300;
    bpu_flush   = 1'b1;
    bpu_target  = 32'h8000_0400;
    tick();
    quiet();
    @(negedge clk);
    chk("cache_refetch", icache_addr, 32'h8000_0300);

    bpu_flush  = 1'b1;
    bpu_target = 32'hFFFF_FFFC;
    tick();
    quiet();
    @(negedge clk);
    chk("wrap_top", icache_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    chk("wrap_zero", icache_addr, 32'h0000_0000);

    reset = 1'b1;
    pf.eret = 1'b1;
    c0_epc  = 32'h8000_0500;
    @(negedge clk);
    chk("midrst_req", icache_req, 0);
    chk("midrst_valid", bus.valid, 0);
    tick();
    @(negedge clk);
    chk("midrst_pc", icache_addr, 32'hBFC0_0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
